// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window stage.
// win_off is also used by the downstream gradient kernel.
package sobel_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int PIX_W_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACTIVE = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

  function automatic int win_off(
    input int r,
    input int c,
    input int pw
  );
    return pw * (3 * r + c);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One-line pixel store: one write port, one registered read port.
// A same-address read and write returns the old contents.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sobel_window.sv
// Line buffers plus 3x3 window register for the Sobel stage.
// Fixed two-cycle latency: RAM read, then window register.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [PIX_W-1:0]   in_data,
  output logic               win_valid,
  output logic               win_sof,
  output logic [9*PIX_W-1:0] win_data,
  output logic [15:0]        win_x,
  output logic [15:0]        win_y
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  state_t        st;
  logic [XW-1:0] xc;
  logic [YW-1:0] yc;

  logic          acc;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          last;
  logic          eol;

  // sof wins over everything, including the final pixel slot
  assign acc  = in_valid & (in_sof | (st == ST_ACTIVE));
  assign px   = in_sof ? '0 : xc;
  assign py   = in_sof ? '0 : yc;
  assign eol  = (px == XW'(IMG_W - 1));
  assign last = eol && (py == YW'(IMG_H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= ST_IDLE;
      xc <= '0;
      yc <= '0;
    end else if (acc) begin
      if (last) begin
        st <= ST_DONE;
        xc <= '0;
        yc <= '0;
      end else begin
        st <= ST_ACTIVE;
        if (eol) begin
          xc <= '0;
          yc <= py + YW'(1);
        end else begin
          xc <= px + XW'(1);
          yc <= py;
        end
      end
    end
  end

  logic             v1;
  logic [PIX_W-1:0] p1;
  logic [XW-1:0]    x1;
  logic [YW-1:0]    y1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      p1 <= '0;
      x1 <= '0;
      y1 <= '0;
    end else begin
      v1 <= acc;
      if (acc) begin
        p1 <= in_data;
        x1 <= px;
        y1 <= py;
      end
    end
  end

  logic [PIX_W-1:0] rd1;
  logic [PIX_W-1:0] rd2;

  // lb1 holds line y-1, lb2 holds line y-2
  sobel_line_buffer #(
    .DEPTH(IMG_W),
    .W    (PIX_W)
  ) u_lb1 (
    .clk  (clk),
    .we   (v1),
    .waddr(x1),
    .wdata(p1),
    .re   (acc),
    .raddr(px),
    .rdata(rd1)
  );

  sobel_line_buffer #(
    .DEPTH(IMG_W),
    .W    (PIX_W)
  ) u_lb2 (
    .clk  (clk),
    .we   (v1),
    .waddr(x1),
    .wdata(rd1),
    .re   (acc),
    .raddr(px),
    .rdata(rd2)
  );

  logic [9*PIX_W-1:0] nxt;
  logic               emit;

  assign emit = v1 && (x1 >= XW'(2)) && (y1 >= YW'(2));

  always_comb begin
    nxt = win_data;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        nxt[win_off(r, c, PIX_W) +: PIX_W] =
          win_data[win_off(r, c + 1, PIX_W) +: PIX_W];
      end
    end
    nxt[win_off(0, 2, PIX_W) +: PIX_W] = rd2;
    nxt[win_off(1, 2, PIX_W) +: PIX_W] = rd1;
    nxt[win_off(2, 2, PIX_W) +: PIX_W] = p1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_sof   <= 1'b0;
      win_data  <= '0;
      win_x     <= '0;
      win_y     <= '0;
    end else begin
      win_valid <= emit;
      win_sof   <= emit && (x1 == XW'(2)) && (y1 == YW'(2));
      if (v1) win_data <= nxt;
      if (emit) begin
        win_x <= 16'(x1) - 16'd1;
        win_y <= 16'(y1) - 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_window.sv
// Directed bench for sobel_window on an 8x6 frame.
// Frame-array model predicts each window and its due cycle.
module tb_sobel_window;

  localparam int W = 8;
  localparam int H = 6;
  localparam int P = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [P-1:0]  in_data = '0;
  logic          win_valid;
  logic          win_sof;
  logic [9*P-1:0] win_data;
  logic [15:0]   win_x;
  logic [15:0]   win_y;

  sobel_window #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_data  (in_data),
    .win_valid(win_valid),
    .win_sof  (win_sof),
    .win_data (win_data),
    .win_x    (win_x),
    .win_y    (win_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [71:0] d;
    int          cx;
    int          cy;
    logic        s;
  } ew_t;

  ew_t         q[$];
  logic [7:0]  fr[H][W];
  int          tot = 0;
  int          bad = 0;
  int          nwin = 0;
  bit          chk_en = 0;
  logic [71:0] sof_d;
  logic [71:0] last_d;
  int          sof_x, sof_y;
  int          last_x, last_y;

  task automatic chk(input string nm, input logic [71:0] got,
                     input logic [71:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, exp);
    end
  endtask

  task automatic model(input int x, input int y, input logic [7:0] d);
    ew_t e;
    fr[y][x] = d;
    if (x >= 2 && y >= 2) begin
      e.due = cyc + 2;
      e.d   = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          e.d[8*(3*r+c) +: 8] = fr[y-2+r][x-2+c];
      e.cx = x - 1;
      e.cy = y - 1;
      e.s  = (x == 2 && y == 2);
      q.push_back(e);
    end
  endtask

  task automatic drive(input bit v, input bit s, input logic [7:0] d,
                       input int x, input int y, input bit trk);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sof   = s;
    in_data  = d;
    if (v && trk) model(x, y, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // pixels start..start+n-1 in raster order, value base+16y+x
  task automatic run(input int base, input int start, input int n,
                     input bit sof, input bit trk, input bit gap);
    int x;
    int y;
    for (int i = start; i < start + n; i++) begin
      x = i % W;
      y = i / W;
      drive(1'b1, sof && (i == start), 8'(base + 16*y + x), x, y, trk);
      if (gap) idle(1);
    end
  endtask

  task automatic monitor();
    ew_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("win_valid", 72'(win_valid), 72'(1));
          chk("win_data", win_data, e.d);
          chk("win_x", 72'(win_x), 72'(e.cx));
          chk("win_y", 72'(win_y), 72'(e.cy));
          chk("win_sof", 72'(win_sof), 72'(e.s));
          nwin++;
          last_d = win_data;
          last_x = int'(win_x);
          last_y = int'(win_y);
          if (win_sof) begin
            sof_d = win_data;
            sof_x = int'(win_x);
            sof_y = int'(win_y);
          end
        end else begin
          chk("idle_valid", 72'(win_valid), 72'(0));
        end
      end
    end
  endtask

  int  n0;
  int  na;
  bit  f2ok;

  initial begin
    fork
      monitor();
      begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
      end
    join_none

    #12;
    chk("rst_valid", 72'(win_valid), 72'(0));
    chk("rst_sof", 72'(win_sof), 72'(0));
    chk("rst_data", win_data, 72'(0));
    chk("rst_x", 72'(win_x), 72'(0));
    chk("rst_y", 72'(win_y), 72'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // no sof yet: everything dropped
    run(0, 0, 10, 1'b0, 1'b0, 1'b0);
    idle(3);

    n0 = nwin;
    run(0, 0, 48, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("f_count", 72'(nwin - n0), 72'(24));
    chk("f_first_tl", 72'(sof_d[7:0]), 72'(8'h00));
    chk("f_first_c", 72'(sof_d[39:32]), 72'(8'h11));
    chk("f_first_br", 72'(sof_d[71:64]), 72'(8'h22));
    chk("f_first_x", 72'(sof_x), 72'(1));
    chk("f_first_y", 72'(sof_y), 72'(1));
    chk("f_last_x", 72'(last_x), 72'(6));
    chk("f_last_y", 72'(last_y), 72'(4));
    chk("f_last_br", 72'(last_d[71:64]), 72'(8'h57));

    // after the frame, no sof: dropped
    run(0, 0, 8, 1'b0, 1'b0, 1'b0);
    idle(3);

    n0 = nwin;
    run(0, 0, 48, 1'b1, 1'b1, 1'b1);
    idle(4);
    chk("gap_count", 72'(nwin - n0), 72'(24));

    // abort at (3,3)
    n0 = nwin;
    run(0, 0, 27, 1'b1, 1'b1, 1'b0);
    run(8'h80, 0, 48, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("abort_count", 72'(nwin - n0), 72'(31));
    chk("abort_f2_c", 72'(sof_d[39:32]), 72'(8'h91));
    f2ok = 1'b1;
    for (int k = 0; k < 9; k++)
      if (sof_d[8*k +: 8] < 8'h80) f2ok = 1'b0;
    chk("abort_f2_clean", 72'(f2ok), 72'(1));

    // reset mid-frame just after (4,3) is taken
    run(0, 0, 29, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    q.delete();
    #1;
    chk("rst_mid_valid", 72'(win_valid), 72'(0));
    idle(3);
    rst = 1'b0;
    run(0, 29, 19, 1'b0, 1'b0, 1'b0);
    idle(3);
    n0 = nwin;
    run(0, 0, 48, 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("rst_new_count", 72'(nwin - n0), 72'(24));

    // back-to-back, sof in the final pixel slot
    n0 = nwin;
    run(0, 0, 47, 1'b1, 1'b1, 1'b0);
    run(8'h80, 0, 10, 1'b1, 1'b1, 1'b0);
    na = nwin - n0;
    chk("b2b_a_count", 72'(na), 72'(23));
    run(8'h80, 10, 38, 1'b0, 1'b1, 1'b0);
    idle(4);
    chk("b2b_b_count", 72'(nwin - n0 - na), 72'(24));
    chk("b2b_b_last_br", 72'(last_d[71:64]), 72'(8'hD7));

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
